// File: rtl/md_pkg.sv
// Shared constants and helpers for the multiply/divide unit.
// The MD_MADD_EN macro enables the multiply-accumulate opcodes (MADD/MADDU/MSUB/MSUBU).
package md_pkg;

  localparam int unsigned MD_W    = 32;
  localparam int unsigned MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam logic [MD_W-1:0] MD_DIV0_LO  = 32'hFFFF_FFFF;
  localparam logic [MD_W-1:0] MD_OVF_LO   = 32'h8000_0000;
  localparam logic [MD_W-1:0] MD_OVF_HI   = 32'h0000_0000;
  localparam logic [MD_W-1:0] MD_INT_MIN  = 32'h8000_0000;
  localparam logic [MD_W-1:0] MD_NEG_ONE  = 32'hFFFF_FFFF;

  // Ops that occupy the unit for the multiply latency.
  function automatic logic md_is_mul(input logic [MD_OP_W-1:0] op);
`ifdef MD_MADD_EN
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
    return op inside {MD_MULT, MD_MULTU};
`endif
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/md_if.sv
// Pipeline-side handshake and result bus of the multiply/divide unit.
interface md_if;
  import md_pkg::*;

  logic                 Start;
  logic [MD_OP_W-1:0]   MDOp;
  logic [MD_W-1:0]      A;
  logic [MD_W-1:0]      B;
  logic                 HiLoRead;
  logic                 Cancel;
  logic                 Busy;
  logic                 MDStall;
  logic [MD_W-1:0]      HI;
  logic [MD_W-1:0]      LO;

  modport master (
    output Start, MDOp, A, B, HiLoRead, Cancel,
    input  Busy, MDStall, HI, LO
  );

  modport slave (
    input  Start, MDOp, A, B, HiLoRead, Cancel,
    output Busy, MDStall, HI, LO
  );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the next {HI,LO}.
// Accumulate inputs and adders exist only when MD_MADD_EN is defined.
module md_arith
  import md_pkg::*;
(
`ifdef MD_MADD_EN
  input  logic [MD_W-1:0]    hi,
  input  logic [MD_W-1:0]    lo,
`endif
  input  logic [MD_OP_W-1:0] op,
  input  logic [MD_W-1:0]    a,
  input  logic [MD_W-1:0]    b,
  output logic [2*MD_W-1:0]  res
);

  logic [2*MD_W-1:0] prod_s;
  logic [2*MD_W-1:0] prod_u;
  logic [MD_W-1:0]   div_a;
  logic [MD_W-1:0]   div_b;
  logic [MD_W-1:0]   q_mag;
  logic [MD_W-1:0]   r_mag;
  logic [MD_W-1:0]   quot;
  logic [MD_W-1:0]   rem;
  logic              is_sdiv;

  // Signed divide runs on magnitudes; signs are restored afterwards.
  always_comb begin
    res     = '0;
    is_sdiv = (op == MD_DIV);
    prod_s  = {{MD_W{a[MD_W-1]}}, a} * {{MD_W{b[MD_W-1]}}, b};
    prod_u  = {{MD_W{1'b0}}, a} * {{MD_W{1'b0}}, b};
    div_a   = (is_sdiv && a[MD_W-1]) ? MD_W'(-a) : a;
    div_b   = (is_sdiv && b[MD_W-1]) ? MD_W'(-b) : b;
    q_mag   = (div_b == '0) ? '0 : div_a / div_b;
    r_mag   = (div_b == '0) ? '0 : div_a % div_b;
    quot    = (is_sdiv && (a[MD_W-1] ^ b[MD_W-1])) ? MD_W'(-q_mag) : q_mag;
    rem     = (is_sdiv && a[MD_W-1]) ? MD_W'(-r_mag) : r_mag;

    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV, MD_DIVU: begin
        if (b == '0) begin
          res = {a, MD_DIV0_LO};
        end else if (is_sdiv && (a == MD_INT_MIN) && (b == MD_NEG_ONE)) begin
          res = {MD_OVF_HI, MD_OVF_LO};
        end else begin
          res = {rem, quot};
        end
      end
`ifdef MD_MADD_EN
      MD_MADD:  res = {hi, lo} + prod_s;
      MD_MADDU: res = {hi, lo} + prod_u;
      MD_MSUB:  res = {hi, lo} - prod_s;
      MD_MSUBU: res = {hi, lo} - prod_u;
`endif
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and EX-stage stall request.
// Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU; otherwise those codes are ignored.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic Clk,
  input  logic Rst,
  md_if.slave  md
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MD_OP_W-1:0] op_q, op_d;
  logic [MD_W-1:0]    a_q, a_d;
  logic [MD_W-1:0]    b_q, b_d;
  logic [MD_W-1:0]    hi_q, hi_d;
  logic [MD_W-1:0]    lo_q, lo_d;
  logic [2*MD_W-1:0]  arith_res;
  logic               busy;

  // HI/LO cannot change while RUN, so the live registers equal the accept-time values.
  md_arith u_arith (
`ifdef MD_MADD_EN
    .hi  (hi_q),
    .lo  (lo_q),
`endif
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (arith_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      MD_IDLE: begin
        if (md.Start && !md.Cancel) begin
          if (md_is_mul(md.MDOp) || md_is_div(md.MDOp)) begin
            state_d = MD_RUN;
            cnt_d   = md_is_mul(md.MDOp) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
            op_d    = md.MDOp;
            a_d     = md.A;
            b_d     = md.B;
          end else if (md.MDOp == MD_MTHI) begin
            hi_d = md.A;
          end else if (md.MDOp == MD_MTLO) begin
            lo_d = md.A;
          end
        end
      end
      MD_RUN: begin
        if (md.Cancel) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d      = MD_IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = arith_res;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy       = (state_q == MD_RUN);
  assign md.Busy    = busy;
  assign md.MDStall = busy & (md.Start | md.HiLoRead);
  assign md.HI      = hi_q;
  assign md.LO      = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, hazard/cancel sequences, random vs. reference model.
module tb_md_unit;
  import md_pkg::*;

  localparam int unsigned MUL_N = 5;
  localparam int unsigned DIV_N = 10;
`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_if bus ();

  md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .Clk (clk),
    .Rst (rst),
    .md  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.Start    = 1'b0;
    bus.MDOp     = MD_NONE;
    bus.A        = '0;
    bus.B        = '0;
    bus.HiLoRead = 1'b0;
    bus.Cancel   = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.Start = 1'b0;
    bus.MDOp  = MD_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.Busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    issue(MD_MTHI, h, 32'h0);
    issue(MD_MTLO, l, 32'h0);
  endtask

  // Reference: new {HI,LO} and busy latency from the arithmetic rules directly.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] ps, pu, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = 64'(sa * sb);
    pu  = {32'h0, a} * {32'h0, b};
    acc = {hi, lo};
    lat = 0;
    model = acc;
    case (op)
      4'd1: begin lat = MUL_N; model = ps; end
      4'd2: begin lat = MUL_N; model = pu; end
      4'd3: begin
        lat = DIV_N;
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        lat = DIV_N;
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
      4'd5: model = {a, lo};
      4'd6: model = {hi, a};
      4'd7:  if (MADD_EN) begin lat = MUL_N; model = acc + ps; end
      4'd8:  if (MADD_EN) begin lat = MUL_N; model = acc + pu; end
      4'd9:  if (MADD_EN) begin lat = MUL_N; model = acc - ps; end
      4'd10: if (MADD_EN) begin lat = MUL_N; model = acc - pu; end
      default: model = acc;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  vec_t vecs[11];

  initial begin
    int          n;
    int          lat;
    logic [63:0] nxt;

    vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h1, MUL_N};
    vecs[1]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h2,         32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    vecs[2]  = '{MD_DIVU,  32'h5,         32'h0,         32'h0, 32'h0, 32'h5,         32'hFFFF_FFFF, DIV_N};
    vecs[3]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h7, 32'h7, 32'h0,         32'h8000_0000, DIV_N};
    vecs[4]  = '{MD_MULT,  32'h3,         32'hFFFF_FFFE, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_N};
    vecs[5]  = '{MD_MTLO,  32'h1234,      32'h0,         32'h0, 32'h0, 32'h0,         32'h1234, 0};
    vecs[6]  = '{MD_MTHI,  32'hABCD,      32'h0,         32'h0, 32'h55, 32'hABCD,     32'h55, 0};
    vecs[7]  = '{MD_MADDU, 32'h1,         32'h1,         32'h0, 32'hFFFF_FFFF,
                 MADD_EN ? 32'h1 : 32'h0, MADD_EN ? 32'h0 : 32'hFFFF_FFFF, MADD_EN ? int'(MUL_N) : 0};
    vecs[8]  = '{MD_MSUB,  32'h2,         32'h3,         32'h0, 32'h10,
                 32'h0, MADD_EN ? 32'hA : 32'h10, MADD_EN ? int'(MUL_N) : 0};
    vecs[9]  = '{MD_DIV,   32'h7,         32'hFFFF_FFFE, 32'h0, 32'h0, 32'h1,         32'hFFFF_FFFD, DIV_N};
    vecs[10] = '{4'd11,    32'h9,         32'h9,         32'h1, 32'h2, 32'h1,         32'h2, 0};

    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_hi", bus.HI, 32'h0);
    chk("reset_lo", bus.LO, 32'h0);
    chk("reset_busy", 32'(bus.Busy), 32'h0);
    chk("reset_stall", 32'(bus.MDStall), 32'h0);

    // Reset in the middle of a multiply must discard it.
    set_hilo(32'h11, 32'h22);
    issue(MD_MULT, 32'd7, 32'd9);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(bus.Busy), 32'h0);
    chk("rst_mid_hi", bus.HI, 32'h0);
    chk("rst_mid_lo", bus.LO, 32'h0);
    repeat (8) tick();
    chk("rst_mid_no_write", bus.LO, 32'h0);

    // Exact multiply timing, then back-to-back acceptance.
    issue(MD_MULT, 32'h3, 32'hFFFF_FFFE);
    for (int i = 1; i <= int'(MUL_N); i++) begin
      chk($sformatf("mult_busy_t%0d", i), 32'(bus.Busy), 32'h1);
      chk($sformatf("mult_hold_lo_t%0d", i), bus.LO, 32'h0);
      tick();
    end
    chk("mult_done_busy", 32'(bus.Busy), 32'h0);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_busy", 32'(bus.Busy), 32'h1);
    wait_idle(n);
    chk("b2b_hi", bus.HI, 32'hFFFF_FFFE);
    chk("b2b_lo", bus.LO, 32'h1);

    // Directed table.
    foreach (vecs[k]) begin
      set_hilo(vecs[k].pre_hi, vecs[k].pre_lo);
      issue(vecs[k].op, vecs[k].a, vecs[k].b);
      wait_idle(n);
      chk($sformatf("vec%0d_lat", k), 32'(n), 32'(vecs[k].lat));
      chk($sformatf("vec%0d_hi", k), bus.HI, vecs[k].exp_hi);
      chk($sformatf("vec%0d_lo", k), bus.LO, vecs[k].exp_lo);
    end

    // HI/LO read while a divide is pending.
    set_hilo(32'h11, 32'h22);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'h2);
    bus.HiLoRead = 1'b1;
    #1;
    n = 0;
    while (bus.Busy === 1'b1 && n < 50) begin
      chk("rd_stall", 32'(bus.MDStall), 32'h1);
      chk("rd_old_lo", bus.LO, 32'h22);
      n++;
      tick();
    end
    chk("rd_stall_cycles", 32'(n), 32'(DIV_N));
    chk("rd_stall_drop", 32'(bus.MDStall), 32'h0);
    chk("rd_new_hi", bus.HI, 32'hFFFF_FFFF);
    chk("rd_new_lo", bus.LO, 32'hFFFF_FFFD);
    bus.HiLoRead = 1'b0;

    // Second Start held in EX while busy, accepted once busy falls.
    issue(MD_MULT, 32'h2, 32'h3);
    bus.Start = 1'b1;
    bus.MDOp  = MD_MTLO;
    bus.A     = 32'hDEAD;
    #1;
    n = 0;
    while (bus.Busy === 1'b1 && n < 50) begin
      chk("st2_stall", 32'(bus.MDStall), 32'h1);
      n++;
      tick();
    end
    chk("st2_mult_hi", bus.HI, 32'h0);
    chk("st2_mult_lo", bus.LO, 32'h6);
    chk("st2_no_stall", 32'(bus.MDStall), 32'h0);
    tick();
    idle_in();
    chk("st2_mtlo", bus.LO, 32'hDEAD);
    chk("st2_idle", 32'(bus.Busy), 32'h0);

    // Cancel in the completion cycle of a divide.
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (DIV_N - 1) tick();
    chk("cancel_pre_busy", 32'(bus.Busy), 32'h1);
    bus.Cancel = 1'b1;
    tick();
    bus.Cancel = 1'b0;
    chk("cancel_busy", 32'(bus.Busy), 32'h0);
    chk("cancel_hi", bus.HI, 32'h0);
    chk("cancel_lo", bus.LO, 32'hDEAD);
    repeat (3) tick();
    chk("cancel_no_late_write", bus.LO, 32'hDEAD);

    // Cancel together with Start suppresses acceptance.
    bus.Start  = 1'b1;
    bus.MDOp   = MD_MULT;
    bus.A      = 32'h5;
    bus.B      = 32'h5;
    bus.Cancel = 1'b1;
    tick();
    bus.MDOp = MD_MTLO;
    tick();
    idle_in();
    chk("start_cancel_busy", 32'(bus.Busy), 32'h0);
    chk("start_cancel_lo", bus.LO, 32'hDEAD);

    // Random ops against the reference model, with occasional cancels.
    set_hilo(32'h0, 32'h0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    for (int it = 0; it < 150; it++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      bit          do_cancel;
      op  = 4'($urandom_range(0, 15));
      a   = rnd_operand();
      b   = rnd_operand();
      nxt = model(op, a, b, m_hi, m_lo, lat);
      do_cancel = (lat > 0) && ($urandom_range(0, 7) == 0);
      issue(op, a, b);
      if (do_cancel) begin
        repeat ($urandom_range(1, lat) - 1) tick();
        bus.Cancel = 1'b1;
        tick();
        bus.Cancel = 1'b0;
        chk($sformatf("rnd%0d_cancel_busy", it), 32'(bus.Busy), 32'h0);
      end else begin
        wait_idle(n);
        chk($sformatf("rnd%0d_lat op=%0d", it, op), 32'(n), 32'(lat));
        {m_hi, m_lo} = nxt;
      end
      chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", it, op, a, b), bus.HI, m_hi);
      chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", it, op, a, b), bus.LO, m_lo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers; sits beside the EX stage of the pipelined CPU.
- Consumes the forwarded EX operands (post-forwarding-mux rs/rt values) plus a decoded op, and produces HI/LO for MFHI/MFLO.
- Reports a stall request to the hazard/stall logic while a result is pending and the pipeline tries to use the unit.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU/MADD*/MSUB* (must be ≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1).

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  EX-stage instruction is an MD op; qualifies MDOp.
- MDOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, others reserved.
- A  input  32  forwarded rs operand.
- B  input  32  forwarded rt operand.
- HiLoRead  input  1  EX-stage instruction is MFHI/MFLO.
- Cancel  input  1  flush of the issuing instruction; aborts the in-flight op.
- Busy  output  1  operation in flight.
- MDStall  output  1  combinational: Busy & (Start | HiLoRead).
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (Rst=1 at an edge): HI=0, LO=0, Busy=0, state=IDLE, counter=0. Reset overrides everything, including an operation in flight.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, counter counts down.
- Accept rule: Start=1, Busy=0, Cancel=0 and a valid code at edge T latches A, B and the op.
  - MULT/DIV class: go to RUN with counter = N, where N = MUL_CYCLES or DIV_CYCLES.
  - Busy is 1 during cycles T+1 … T+N.
  - HI/LO are written at the edge ending cycle T+N; Busy=0 and new HI/LO are visible from cycle T+N+1.
  - Back-to-back: a Start in cycle T+N+1 is accepted.
- MTHI/MTLO: single cycle, no Busy. HI or LO takes A at edge T.
- Start while Busy: not accepted. MDStall=1 holds the instruction in EX until Busy falls.
- HiLoRead while Busy: MDStall=1. HI/LO always show the last committed values.
- Cancel:
  - In RUN, Cancel at an edge returns to IDLE with HI/LO unchanged.
  - Cancel coinciding with Start suppresses acceptance.
  - Cancel in the completion cycle (counter=1) aborts; no write occurs.
- Arithmetic:
  - MULT: signed 32×32→64. MULTU: unsigned. {HI,LO} = product.
  - DIV: signed, LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. DIVU: unsigned.
  - Divide by zero: LO = 32'hFFFFFFFF, HI = A.
  - Signed overflow (A=32'h80000000, B=32'hFFFFFFFF): LO = 32'h80000000, HI = 0.
  - MADD*/MSUB*: {HI,LO} ± product, 64-bit wrap-around, using the HI/LO committed at accept time.
- Reserved or NONE codes with Start=1: no effect.

Optional Feature:
- Macro MD_MADD_EN.
  - Defined: codes 7–10 behave as above with MUL_CYCLES latency.
  - Undefined: codes 7–10 are treated as reserved (no state change, Busy stays 0), and no accumulator adder is synthesised.

Decomposition:
- Shared package md_pkg holds:
  - MDOp code constants (MD_NONE … MD_MSUBU);
  - state encoding (MD_IDLE, MD_RUN);
  - div-by-zero and overflow result constants.
- One sub-module, md_arith: purely combinational.
  - Inputs: latched operands, op, committed HI/LO.
  - Output: 64-bit result.
  - Keeps md_unit limited to FSM, counter, registers and stall logic.

Test Plan:
- Reset mid-operation: MULT 7×9, assert Rst in cycle T+2 → next cycle HI=0, LO=0, Busy=0; no later write.
- MULT timing: A=3, B=32'hFFFFFFFE, Start at T → Busy=1 in T+1..T+5; at T+6 HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
- MULTU and DIV cases:
  - MULTU A=B=32'hFFFFFFFF → HI=32'hFFFFFFFE, LO=1.
  - DIV A=-7, B=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF after DIV_CYCLES.
- Boundary divides:
  - DIVU by 0, A=5 → LO=32'hFFFFFFFF, HI=5.
  - DIV 32'h80000000/32'hFFFFFFFF → LO=32'h80000000, HI=0.
- Hazards:
  - HiLoRead=1 during Busy → MDStall=1 until Busy falls, then the old value becomes the new value.
  - Second Start during Busy → not accepted, MDStall=1.
- Cancel and MD_MADD_EN:
  - Cancel at counter=1 during DIV → HI/LO keep prior values, Busy=0 the next cycle.
  - MTLO A=32'h1234 → LO=32'h1234 the next cycle.
  - With MD_MADD_EN: HI=0, LO=32'hFFFFFFFF, MADDU 1×1 → HI=1, LO=0. Without it, the same stimulus leaves HI/LO unchanged.
